// File: rtl/datapath_unit.sv
// Datapath unit: ALU with a registered result and flags, plus a 32-word data
// memory with a registered read port. The registered ALU result is the memory
// address. result2 selects between the ALU register and the memory read register.
module datapath_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    input  logic [DATA_WIDTH-1:0] offset,
    input  logic [3:0]            opcode,
    input  logic                  sel1,
    input  logic                  sel3,
    input  logic                  w_r,
    output logic [DATA_WIDTH-1:0] result2,
    output logic                  zero,
    output logic                  carry
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_SHL   = 4'b0110;
    localparam logic [3:0] OP_SHR   = 4'b0111;
    localparam logic [3:0] OP_PASSA = 4'b1000;
    localparam logic [3:0] OP_PASSB = 4'b1001;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    logic [DATA_WIDTH-1:0] b_operand;
    logic [3:0]            alu_op;
    logic                  alu_hold;
    logic [DATA_WIDTH:0]   wide_sum;
    logic [DATA_WIDTH:0]   wide_diff;
    logic [DATA_WIDTH-1:0] alu_result_next;
    logic                  alu_carry_next;

    logic [DATA_WIDTH-1:0] alu_q_reg;
    logic                  zero_reg;
    logic                  carry_reg;
    logic [DATA_WIDTH-1:0] mem_q_reg;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0] mem_words [DEPTH];

    // Address-generation mode swaps in the displacement and forces an add,
    // which also overrides NOP so the address register always advances.
    assign b_operand = sel3 ? offset : operand2;
    assign alu_op    = sel3 ? OP_ADD : opcode;
    assign alu_hold  = (alu_op == OP_NOP);

    // One extra bit on each side gives the carry-out of ADD and the borrow of SUB.
    assign wide_sum  = {1'b0, operand1} + {1'b0, b_operand};
    assign wide_diff = {1'b0, operand1} - {1'b0, b_operand};

    // ALU result and carry for the effective operation; unlisted codes yield 0.
    always_comb begin
        alu_result_next = '0;
        alu_carry_next  = 1'b0;
        case (alu_op)
            OP_ADD:   {alu_carry_next, alu_result_next} = wide_sum;
            OP_SUB:   {alu_carry_next, alu_result_next} = wide_diff;
            OP_AND:   alu_result_next = operand1 & b_operand;
            OP_OR:    alu_result_next = operand1 | b_operand;
            OP_XOR:   alu_result_next = operand1 ^ b_operand;
            OP_NOT:   alu_result_next = ~operand1;
            OP_SHL: begin
                alu_result_next = {operand1[DATA_WIDTH-2:0], 1'b0};
                alu_carry_next  = operand1[DATA_WIDTH-1];
            end
            OP_SHR: begin
                alu_result_next = {1'b0, operand1[DATA_WIDTH-1:1]};
                alu_carry_next  = operand1[0];
            end
            OP_PASSA: alu_result_next = operand1;
            OP_PASSB: alu_result_next = b_operand;
            default:  alu_result_next = '0;
        endcase
    end

    // ALU result register and flags; all three hold together on NOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_q_reg <= '0;
            zero_reg  <= 1'b0;
            carry_reg <= 1'b0;
        end else if (!alu_hold) begin
            alu_q_reg <= alu_result_next;
            zero_reg  <= (alu_result_next == '0);
            carry_reg <= alu_carry_next;
        end
    end

    // Upper bits of the ALU register are ignored, so addresses wrap.
    assign mem_addr = alu_q_reg[ADDR_BITS-1:0];

    // Each word is its own register so reset can preload it with its index.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            localparam logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(gi);
            localparam logic [ADDR_BITS-1:0]  WORD_ADDR  = ADDR_BITS'(gi);

            logic [DATA_WIDTH-1:0] word_reg;

            // Write operand2 when this word is addressed and w_r is high.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_reg <= INIT_VALUE;
                end else if (w_r && (mem_addr == WORD_ADDR)) begin
                    word_reg <= operand2;
                end
            end

            assign mem_words[gi] = word_reg;
        end
    endgenerate

    // Registered read samples the pre-edge word, giving read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q_reg <= '0;
        end else begin
            mem_q_reg <= mem_words[mem_addr];
        end
    end

    assign result2 = sel1 ? alu_q_reg : mem_q_reg;
    assign zero    = zero_reg;
    assign carry   = carry_reg;

endmodule
